uart_io: RTL and testbench

- Memory-mapped UART peripheral directly downstream of the Hack memory-map decoder.
- Consumes two decoded strobes from the decoder: TX data write and RX acknowledge.
- Produces two 16-bit read words that feed the decoder's IO read inputs.
- Serial format 8N1, LSB first, one clock domain.

---
 rtl/uart_io_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 46 ++++
 rtl/uart_io.sv | 173 +++++++++++++++++
 tb/tb_uart_io.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared definitions for the uart_io peripheral: FSM encodings, status bit positions, defaults.
// Optional RX FIFO build is selected with UART_IO_RX_FIFO_EN (see uart_io.sv).
package uart_io_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int          BUSY_BIT         = 15;
    localparam int          EMPTY_BIT        = 15;
    localparam int          OVR_BIT          = 14;
    localparam logic [15:0] RX_EMPTY_WORD    = 16'(1) << EMPTY_BIT;
    localparam int          DEFAULT_BAUD_DIV = 217;

    function automatic logic [15:0] rx_word(input logic ovr, input logic [7:0] data);
        rx_word          = '0;
        rx_word[OVR_BIT] = ovr;
        rx_word[7:0]     = data;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two RX byte FIFO; a pop frees a slot for a push in the same cycle.
// Only compiled in builds with UART_IO_RX_FIFO_EN.
`ifdef UART_IO_RX_FIFO_EN
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           rd_ptr, wr_ptr;
    logic [AW:0]             count;
    logic                    do_pop, do_push;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule
`endif

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART for the Hack IO decoder: TX data/status word and RX data word.
// Define UART_IO_RX_FIFO_EN to replace the RX holding register with a 4-entry FIFO.
module uart_io
    import uart_io_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV   // must be >= 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        loadTX,
    input  logic        loadRX,
    output logic [15:0] outTX,
    output logic [15:0] outRX,
    output logic        tx,
    input  logic        rx
);
    localparam int            CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Upper write bits carry no function for this peripheral.
    logic unused_in_hi;
    assign unused_in_hi = ^in[15:8];

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_data;
    logic          busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: if (loadTX) begin
                    tx_data  <= in[7:0];
                    tx_cnt   <= '0;
                    tx       <= 1'b0;
                    busy     <= 1'b1;
                    tx_state <= TX_START;
                end
                TX_START: if (tx_cnt == LAST) begin
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    tx       <= tx_data[0];
                    tx_state <= TX_DATA;
                end else tx_cnt <= tx_cnt + ONE;
                TX_DATA: if (tx_cnt == LAST) begin
                    tx_cnt <= '0;
                    if (tx_bit == 3'd7) begin
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_bit <= tx_bit + 3'd1;
                        tx     <= tx_data[tx_bit + 3'd1];
                    end
                end else tx_cnt <= tx_cnt + ONE;
                TX_STOP: if (tx_cnt == LAST) begin
                    tx_cnt   <= '0;
                    busy     <= 1'b0;
                    tx_state <= TX_IDLE;
                end else tx_cnt <= tx_cnt + ONE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign outTX = 16'(busy) << BUSY_BIT;

    rx_state_t     rx_state;
    logic [1:0]    rx_sync;
    logic          rx_s;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_commit;

    assign rx_s      = rx_sync[1];
    assign rx_commit = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s;

    // rx_cnt counts down to each sample point; START waits half a bit to centre sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            case (rx_state)
                RX_IDLE: if (!rx_s) begin
                    rx_cnt   <= HALF;
                    rx_state <= RX_START;
                end
                RX_START: if (rx_cnt != '0) rx_cnt <= rx_cnt - ONE;
                else if (rx_s) rx_state <= RX_IDLE;
                else begin
                    rx_cnt   <= LAST;
                    rx_bit   <= '0;
                    rx_state <= RX_DATA;
                end
                RX_DATA: if (rx_cnt != '0) rx_cnt <= rx_cnt - ONE;
                else begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_cnt   <= LAST;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end
                RX_STOP: if (rx_cnt != '0) rx_cnt <= rx_cnt - ONE;
                else rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_IO_RX_FIFO_EN
    logic [7:0] head;
    logic       full, empty, ovr;

    uart_rx_fifo #(.DEPTH(4), .W(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_commit),
        .pop   (loadRX),
        .wdata (rx_shift),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // A pop in the same cycle frees the slot, so only an unpopped full FIFO overruns.
    always_ff @(posedge clk) begin
        if (reset) ovr <= 1'b0;
        else if (loadRX && !empty) ovr <= 1'b0;
        else if (rx_commit && full) ovr <= 1'b1;
    end

    assign outRX = empty ? RX_EMPTY_WORD : rx_word(ovr, head);
`else
    logic [7:0] hold;
    logic       valid, ovr;

    // An acknowledge coincident with a commit retires the old byte and keeps the new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold  <= '0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else if (rx_commit) begin
            if (!valid || loadRX) begin
                hold  <= rx_shift;
                valid <= 1'b1;
                ovr   <= 1'b0;
            end else ovr <= 1'b1;
        end else if (loadRX) begin
            valid <= 1'b0;
            ovr   <= 1'b0;
        end
    end

    assign outRX = valid ? rx_word(ovr, hold) : RX_EMPTY_WORD;
`endif

endmodule

// File: tb/tb_uart_io.sv
// Directed + randomized bench for uart_io at BAUD_DIV=8 with a queue-based RX model.
// Build with UART_IO_RX_FIFO_EN defined to check the FIFO variant.
module tb_uart_io;
    localparam int BD = 8;
`ifdef UART_IO_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, loadTX, loadRX, rx;
    logic [15:0] din;
    logic [15:0] outTX, outRX;
    logic        tx;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mq[$];
    bit         movr;

    uart_io #(.BAUD_DIV(BD)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (din),
        .loadTX (loadTX),
        .loadRX (loadRX),
        .outTX  (outTX),
        .outRX  (outRX),
        .tx     (tx),
        .rx     (rx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Receive-side reference: a bounded queue of bytes plus a sticky overrun flag.
    function automatic void model_reset();
        mq.delete();
        movr = 1'b0;
    endfunction

    function automatic void model_commit(input logic [7:0] b);
        if (mq.size() < CAP) mq.push_back(b);
        else movr = 1'b1;
    endfunction

    function automatic void model_pop();
        if (mq.size() > 0) void'(mq.pop_front());
        movr = 1'b0;
    endfunction

    function automatic logic [15:0] model_word();
        if (mq.size() == 0) return 16'h8000;
        return {1'b0, movr, 6'b0, mq[0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Launch one TX frame and sample every bit at its middle; optionally poke loadTX
    // mid-frame (must be ignored) or on the cycle busy falls (must also be ignored).
    task automatic tx_frame(input logic [7:0] b, input bit poke_mid, input bit poke_end);
        logic [9:0] got;
        logic [9:0] exp;
        exp = {1'b1, b, 1'b0};
        @(negedge clk);
        din    = {8'($urandom), b};
        loadTX = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            loadTX = 1'b0;
            din    = 16'h0000;
            if (i == 1) check("tx_busy_set", outTX, 16'h8000);
            if (i % 8 == 4) got[i/8] = tx;
            if (poke_mid && i == 20) begin
                din    = 16'h0033;
                loadTX = 1'b1;
            end
            if (i == 80) begin
                check("tx_busy_last", outTX, 16'h8000);
                if (poke_end) begin
                    din    = 16'h005A;
                    loadTX = 1'b1;
                end
            end
        end
        @(negedge clk);
        loadTX = 1'b0;
        din    = 16'h0000;
        check("tx_busy_clear", outTX, 16'h0000);
        for (int k = 0; k < 10; k++) check($sformatf("tx_bit%0d", k), 16'(got[k]), 16'(exp[k]));
        if (poke_end || poke_mid) begin
            idle(20);
            check("tx_no_restart_busy", outTX, 16'h0000);
            check("tx_no_restart_line", 16'(tx), 16'h0001);
        end
    endtask

    // Drive one 8N1 frame on rx; optionally acknowledge on the exact commit cycle.
    task automatic rx_frame(input logic [7:0] b, input bit stop, input bit pop_at_commit);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < BD; c++) begin
                @(negedge clk);
                rx     = f[k];
                loadRX = pop_at_commit && (k == 9) && (c == BD - 1);
            end
        end
        @(negedge clk);
        loadRX = 1'b0;
        rx     = 1'b1;
        if (pop_at_commit) model_pop();
        if (stop) model_commit(b);
        check($sformatf("rx_frame_%h", b), outRX, model_word());
        idle(12);
    endtask

    task automatic rx_pop();
        @(negedge clk);
        loadRX = 1'b1;
        @(negedge clk);
        loadRX = 1'b0;
        model_pop();
        check("rx_pop", outRX, model_word());
    endtask

    initial begin
        reset = 1'b1; din = '0; loadTX = 1'b0; loadRX = 1'b0; rx = 1'b1;
        model_reset();
        idle(2);
        check("reset_tx", 16'(tx), 16'h0001);
        check("reset_outTX", outTX, 16'h0000);
        check("reset_outRX", outRX, 16'h8000);
        reset = 1'b0;
        idle(2);

        tx_frame(8'hA5, 1'b0, 1'b0);
        tx_frame(8'hA5, 1'b1, 1'b0);
        tx_frame(8'($urandom), 1'b0, 1'b1);
        repeat (2) tx_frame(8'($urandom), 1'b0, 1'b0);

        rx_frame(8'h3C, 1'b1, 1'b0);
        check("rx_3c_word", outRX, 16'h003C);
        rx_pop();
        check("rx_3c_cleared", outRX, 16'h8000);

        rx_frame(8'h11, 1'b1, 1'b0);
        rx_frame(8'h22, 1'b1, 1'b0);
`ifdef UART_IO_RX_FIFO_EN
        check("rx_two_frames", outRX, 16'h0011);
`else
        check("rx_overrun", outRX, 16'h4011);
`endif
        rx_pop();
        rx_pop();
        check("rx_drained", outRX, 16'h8000);

        @(negedge clk); rx = 1'b0;
        idle(2);
        @(negedge clk); rx = 1'b1;
        idle(40);
        check("rx_glitch", outRX, 16'h8000);

        rx_frame(8'h55, 1'b0, 1'b0);
        check("rx_framing", outRX, 16'h8000);

        // Fill to capacity, overrun once, then acknowledge exactly on a commit.
        repeat (CAP) rx_frame(8'($urandom), 1'b1, 1'b0);
        rx_frame(8'($urandom), 1'b1, 1'b0);
        rx_frame(8'($urandom), 1'b1, 1'b1);
        repeat (CAP + 1) rx_pop();

        for (int n = 0; n < 10; n++) begin
            rx_frame(8'($urandom), 1'b1, 1'b0);
            if ($urandom_range(0, 2) == 0) rx_pop();
        end
        repeat (CAP + 1) rx_pop();

        // Reset in the middle of a TX frame with an RX byte pending.
        rx_frame(8'($urandom), 1'b1, 1'b0);
        @(negedge clk); din = 16'h00C3; loadTX = 1'b1;
        @(negedge clk); loadTX = 1'b0;
        idle(30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("midreset_tx", 16'(tx), 16'h0001);
        check("midreset_outTX", outTX, 16'h0000);
        check("midreset_outRX", outRX, model_word());
        tx_frame(8'($urandom), 1'b0, 1'b0);
        rx_frame(8'($urandom), 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
